// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the accumulator CPU. Resolves HLT/JMP/JZ
// itself and strobes exec_en for every other opcode.
module cpu_seq_ctrl #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  output logic [PC_W-1:0]  mem_addr,
  output logic             mem_rd_en,
  input  logic [7:0]       mem_rdata,
  input  logic             acc_zero,
  output logic [7:0]       ir,
  output logic             exec_en,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [1:0] C_CLR  = 2'b00;
  localparam logic [1:0] C_RUN  = 2'b01;
  localparam logic [1:0] C_STEP = 2'b10;
  localparam logic [1:0] C_HALT = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_mode_q, run_mode_d;
  logic             halt_pend_q, halt_pend_d;
  logic             exec_en_q, exec_en_d;
  logic             rd_en_q, rd_en_d;

  logic            cmd_acc, halt_req, ctrl_op;
  logic [PC_W-1:0] pc_inc, pc_tgt;

  assign running   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALTED);
  assign cmd_ready = (state_q == S_IDLE) || halted || (running && run_mode_q);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign halt_req  = cmd_acc && (cmd == C_HALT);
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_tgt    = PC_W'(ir_q[3:0]);
  // Control-flow opcodes are resolved here and never reach the datapath.
  assign ctrl_op   = (mem_rdata[7:4] == 4'hD) || (mem_rdata[7:4] == 4'hE) ||
                     (mem_rdata[7:4] == 4'hF);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    run_mode_d  = run_mode_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (cmd)
            C_CLR:  begin pc_d = '0; cnt_d = '0; end
            C_RUN:  begin run_mode_d = 1'b1; state_d = S_FETCH; end
            C_STEP: begin run_mode_d = 1'b0; state_d = S_FETCH; end
            default: ;
          endcase
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
        if (halt_req) halt_pend_d = 1'b1;
      end
      S_DECODE: begin
        ir_d    = mem_rdata;
        state_d = S_EXEC;
        if (halt_req) halt_pend_d = 1'b1;
      end
      S_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        case (ir_q[7:4])
          4'hF:    pc_d = pc_q;
          4'hE:    pc_d = pc_tgt;
          4'hD:    pc_d = acc_zero ? pc_tgt : pc_inc;
          default: pc_d = pc_inc;
        endcase
        if (ir_q[7:4] == 4'hF) begin
          state_d     = S_HALTED;
          run_mode_d  = 1'b0;
          halt_pend_d = 1'b0;
        end else if (run_mode_q && !halt_pend_q && !halt_req) begin
          state_d = S_FETCH;
        end else begin
          state_d     = S_IDLE;
          run_mode_d  = 1'b0;
          halt_pend_d = 1'b0;
        end
      end
      S_HALTED: begin
        if (cmd_acc && (cmd == C_CLR)) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rd_en_d   = (state_d == S_FETCH);
    exec_en_d = (state_q == S_DECODE) && !ctrl_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      cnt_q       <= '0;
      run_mode_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      exec_en_q   <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      run_mode_q  <= run_mode_d;
      halt_pend_q <= halt_pend_d;
      exec_en_q   <= exec_en_d;
      rd_en_q     <= rd_en_d;
    end
  end

  assign mem_addr  = pc_q;
  assign mem_rd_en = rd_en_q;
  assign ir        = ir_q;
  assign exec_en   = exec_en_q;
  assign pc        = pc_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: synchronous program memory model plus a queue of
// expected exec_en instructions checked by a monitor.
module tb_cpu_seq_ctrl;
  localparam int PC_W = 4, CNT_W = 16;
  localparam logic [1:0] C_CLR = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, acc_zero = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic cmd_ready, mem_rd_en, exec_en, running, halted;
  logic [PC_W-1:0] mem_addr, pc;
  logic [7:0] mem_rdata = 8'h00, ir;
  logic [CNT_W-1:0] instr_cnt;

  logic [7:0] prog [16];
  logic [7:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  cpu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .acc_zero(acc_zero), .ir(ir), .exec_en(exec_en), .pc(pc), .running(running),
    .halted(halted), .instr_cnt(instr_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= prog[mem_addr];

  // Every exec_en pulse must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && exec_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL exec_unexpected: exec_en=1 ir=%h, required no pulse", ir);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ir !== e) begin
          n_fail++;
          $display("FAIL exec_ir: ir=%h required %h", ir, e);
        end
      end
    end
  end

  task automatic load(input int a0, input logic [7:0] v0, input int a1, input logic [7:0] v1);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[a0] = v0;
    prog[a1] = v1;
  endtask

  task automatic send_cmd(input logic [1:0] c);
    int g = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd = c;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    int g = 0;
    while (running && g < 100) begin @(negedge clk); g++; end
    ok = !running;
  endtask

  task automatic wait_rd(output logic ok);
    int g = 0;
    do begin @(negedge clk); g++; end while (!mem_rd_en && g < 50);
    ok = mem_rd_en;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({exec_en, mem_rd_en, running, halted, cmd_ready} !== 5'b00001 || pc !== 0 || ir !== 0 || instr_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_vals: en/rd/run/hlt/rdy=%b pc=%0d ir=%h cnt=%0d required 00001 0 00 0",
               {exec_en, mem_rd_en, running, halted, cmd_ready}, pc, ir, instr_cnt);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_step();
    logic ok;
    load(0, 8'h12, 1, 8'h00);
    send_cmd(C_CLR);
    exp_q.push_back(8'h12);
    send_cmd(C_STEP);
    n_chk++;
    if (mem_rd_en !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL step_fetch: rd=%b rdy=%b required 1 0", mem_rd_en, cmd_ready);
    end
    @(negedge clk);
    n_chk++;
    if (mem_rd_en !== 1'b0 || cmd_ready !== 1'b0 || exec_en !== 1'b0) begin
      n_fail++; $display("FAIL step_decode: rd=%b rdy=%b en=%b required 0 0 0", mem_rd_en, cmd_ready, exec_en);
    end
    @(negedge clk);
    n_chk++;
    if (exec_en !== 1'b1 || ir !== 8'h12 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL step_exec: en=%b ir=%h rdy=%b required 1 12 0", exec_en, ir, cmd_ready);
    end
    @(negedge clk);
    wait_idle(ok);
    n_chk++;
    if (!ok || exec_en !== 1'b0 || pc !== 1 || instr_cnt !== 1 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL step_done: en=%b pc=%0d cnt=%0d rdy=%b required 0 1 1 1", exec_en, pc, instr_cnt, cmd_ready);
    end
  endtask

  task automatic test_run_jmp();
    logic ok;
    load(0, 8'h11, 1, 8'h22);
    prog[2] = 8'hE0;
    send_cmd(C_CLR);
    exp_q.push_back(8'h11);
    send_cmd(C_RUN);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) wait_rd(ok); else ok = mem_rd_en;
      if (i % 3 != 2 && i > 0) exp_q.push_back(prog[i % 3]);
      n_chk++;
      if (!ok || mem_addr !== PC_W'(i % 3)) begin
        n_fail++; $display("FAIL run_fetch_addr: fetch %0d addr=%0d rd=%b required %0d", i, mem_addr, ok, i % 3);
      end
    end
    send_cmd(C_HALT);
    wait_idle(ok);
    n_chk++;
    if (!ok || pc !== 0 || instr_cnt !== 6 || halted !== 1'b0) begin
      n_fail++; $display("FAIL run_stop: pc=%0d cnt=%0d hlt=%b required 0 6 0", pc, instr_cnt, halted);
    end
  endtask

  task automatic test_halt_cmd();
    logic ok, saw_rd;
    int g;
    load(0, 8'hE5, 5, 8'h13);
    prog[6] = 8'h14;
    send_cmd(C_CLR);
    send_cmd(C_RUN);
    g = 0;
    while (!(mem_rd_en && mem_addr == 5) && g < 20) begin wait_rd(ok); g++; end
    n_chk++;
    if (!(mem_rd_en && mem_addr == 5)) begin
      n_fail++; $display("FAIL halt_reach5: addr=%0d rd=%b required 5 1", mem_addr, mem_rd_en);
    end
    exp_q.push_back(8'h13);
    send_cmd(C_HALT);
    wait_idle(ok);
    n_chk++;
    if (!ok || pc !== 6 || instr_cnt !== 2) begin
      n_fail++; $display("FAIL halt_done: pc=%0d cnt=%0d required 6 2", pc, instr_cnt);
    end
    saw_rd = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (mem_rd_en) saw_rd = 1'b1; end
    n_chk++;
    if (saw_rd !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL halt_no_fetch: rd_seen=%b run=%b required 0 0", saw_rd, running);
    end
  endtask

  task automatic test_jz();
    logic ok;
    load(0, 8'hE3, 3, 8'hD9);
    for (int k = 0; k < 2; k++) begin
      send_cmd(C_CLR);
      send_cmd(C_STEP);
      wait_idle(ok);
      acc_zero = (k == 0);
      send_cmd(C_STEP);
      wait_idle(ok);
      n_chk++;
      if (!ok || pc !== PC_W'(k == 0 ? 9 : 4) || instr_cnt !== 2) begin
        n_fail++; $display("FAIL jz_acc%0d: pc=%0d cnt=%0d required %0d 2", 1 - k, pc, instr_cnt, k == 0 ? 9 : 4);
      end
    end
    acc_zero = 1'b0;
  endtask

  task automatic test_hlt_op();
    int g = 0;
    load(0, 8'hE7, 7, 8'hF0);
    send_cmd(C_CLR);
    send_cmd(C_RUN);
    while (!halted && g < 50) begin @(negedge clk); g++; end
    n_chk++;
    if (halted !== 1'b1 || pc !== 7 || instr_cnt !== 2 || running !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL hlt_state: hlt=%b pc=%0d cnt=%0d run=%b rdy=%b required 1 7 2 0 1",
                         halted, pc, instr_cnt, running, cmd_ready);
    end
    send_cmd(C_RUN);
    repeat (3) @(negedge clk);
    n_chk++;
    if (halted !== 1'b1 || pc !== 7 || mem_rd_en !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("FAIL hlt_sticky: hlt=%b pc=%0d rd=%b run=%b required 1 7 0 0", halted, pc, mem_rd_en, running);
    end
    send_cmd(C_CLR);
    n_chk++;
    if (halted !== 1'b0 || running !== 1'b0 || pc !== 0 || instr_cnt !== 0) begin
      n_fail++; $display("FAIL hlt_clr: hlt=%b run=%b pc=%0d cnt=%0d required 0 0 0 0", halted, running, pc, instr_cnt);
    end
  endtask

  task automatic test_pc_wrap();
    logic ok;
    load(0, 8'hEF, 15, 8'h15);
    send_cmd(C_CLR);
    send_cmd(C_STEP);
    wait_idle(ok);
    exp_q.push_back(8'h15);
    send_cmd(C_STEP);
    wait_idle(ok);
    n_chk++;
    if (!ok || pc !== 0 || instr_cnt !== 2) begin
      n_fail++; $display("FAIL pc_wrap: pc=%0d cnt=%0d required 0 2", pc, instr_cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    int g = 0;
    load(0, 8'h12, 1, 8'h00);
    send_cmd(C_CLR);
    exp_q.push_back(8'h12);
    send_cmd(C_STEP);
    while (!exec_en && g < 20) begin @(negedge clk); g++; end
    n_chk++;
    if (exec_en !== 1'b1) begin n_fail++; $display("FAIL rst_reach_exec: en=%b required 1", exec_en); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({exec_en, mem_rd_en, running, halted, cmd_ready} !== 5'b00001 || pc !== 0 || ir !== 0 || instr_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_exec: en/rd/run/hlt/rdy=%b pc=%0d ir=%h cnt=%0d required 00001 0 00 0",
               {exec_en, mem_rd_en, running, halted, cmd_ready}, pc, ir, instr_cnt);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_jmp();
    test_halt_cmd();
    test_jz();
    test_hlt_op();
    test_pc_wrap();
    test_reset_mid_exec();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL exec_missing: %0d expected pulses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Fetch/decode/execute sequencer for the tiny accumulator CPU datapath. It drives the program-memory address and read strobe, latches the instruction register, and resolves control-flow opcodes (HLT, JMP, JZ) itself. All other opcodes are handed to the datapath with a one-cycle execute strobe. A host issues RUN/STEP/HALT/CLR commands over a valid/ready handshake.

Parameters:
PC_W, 4, program counter / memory address width
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  host command valid
cmd  input  2  00=CLR, 01=RUN, 10=STEP, 11=HALT
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
mem_addr  output  PC_W  program memory address (= pc)
mem_rd_en  output  1  synchronous memory read strobe; data returns next cycle
mem_rdata  input  8  instruction byte: opcode[7:4], operand[3:0]
acc_zero  input  1  datapath accumulator == 0, sampled in EXEC
ir  output  8  instruction register
exec_en  output  1  one-cycle strobe: datapath executes ir
pc  output  PC_W  program counter
running  output  1  high in FETCH/DECODE/EXEC
halted  output  1  high in HALTED
instr_cnt  output  CNT_W  retired instructions, wraps

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=0, ir=0, instr_cnt=0, run_mode=0. Outputs: exec_en=0, mem_rd_en=0, running=0, halted=0, cmd_ready=1.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
- Each instruction takes 3 cycles:
  - FETCH: mem_rd_en=1, mem_addr=pc.
  - DECODE: ir <= mem_rdata.
  - EXEC: act on ir, update pc, instr_cnt+1.
- EXEC actions by opcode:
  - 0xF HLT: pc unchanged, go to HALTED, exec_en=0.
  - 0xE JMP: pc <= operand (zero-extended to PC_W), exec_en=0.
  - 0xD JZ: if acc_zero, pc <= operand, else pc+1; exec_en=0.
  - All other opcodes: exec_en=1, pc <= pc+1.
  - pc wraps modulo 2^PC_W (e.g. 15 -> 0).
- After EXEC: go to FETCH if run_mode=1 and no halt pending; otherwise go to IDLE and clear run_mode.
- cmd_ready:
  - 1 in IDLE and HALTED.
  - 1 while running with run_mode=1, so HALT can be accepted.
  - 0 while running a STEP (run_mode=0).
- Commands in IDLE:
  - RUN: run_mode=1, go to FETCH next cycle.
  - STEP: run_mode=0, go to FETCH, execute exactly one instruction, return to IDLE.
  - CLR: pc=0, instr_cnt=0.
  - HALT: no effect.
- Commands in HALTED:
  - CLR: pc=0, instr_cnt=0, go to IDLE.
  - RUN/STEP/HALT: consumed, no effect. HALTED is sticky until CLR or rst.
- Commands while running (RUN mode):
  - HALT sets halt_pending. The current instruction completes through EXEC (exec_en and pc update still occur), then go to IDLE. No new FETCH is issued.
  - RUN/STEP/CLR are consumed and ignored.
- A HLT opcode retires: instr_cnt increments.
- HALT accepted in the same cycle as an EXEC of HLT: HALTED wins.
- instr_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-instruction aborts immediately. No exec_en pulse is produced after rst asserts.
- All outputs are registered, except: mem_addr (= pc), running, halted, cmd_ready (decoded from state).

Test Plan:
- STEP, program[0]=0x12 -> mem_rd_en at cycle 1; ir=0x12 at cycle 2; exec_en single pulse at cycle 3; pc=1, instr_cnt=1; back in IDLE; cmd_ready=0 during cycles 1-3.
- RUN, program {0x11, 0x22, 0xE0 at addr 2} -> exec_en pulses every 3 cycles; pc sequence 0,1,2,0,1,...; no exec_en on JMP.
- RUN, then HALT asserted during DECODE of the instruction at pc=5 -> that instruction's exec_en still fires; pc=6; IDLE; no further mem_rd_en.
- JZ 0xD9 at pc=3: with acc_zero=1 -> pc=9; with acc_zero=0 -> pc=4.
- HLT 0xF0 at pc=7 under RUN -> halted=1, pc=7, instr_cnt incremented. RUN ignored while halted. CLR -> pc=0, instr_cnt=0, IDLE.
- Assert rst during EXEC of an ALU op -> exec_en=0 in the same cycle; all outputs at reset values. Also cover pc wrap 15 -> 0 with a non-control op at addr 15.
